uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte streams share one 8N1 UART transmitter, keeping bursts whole.
// Define UART_ARB_WDOG_EN to release an owner that stalls mid-burst for WDOG_CYCLES cycles.
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int WDOG_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic                 wdog_err
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

   if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1) begin : g_bad_cfg
      $error("uart_tx_arbiter: unsupported NUM_REQ or WDOG_CYCLES");
   end

   typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE, NEXT} state_t;

   state_t        state;
   logic [IW-1:0] owner;
   logic [IW-1:0] last_owner;
   logic          last_q;

   logic [IW-1:0] sel_idx;
   logic [IW-1:0] cand;
   logic          sel_found;
   logic [7:0]    own_byte;
   logic          own_valid;
   logic          own_last;

   // Search starts one past the previous owner so every requester gets a turn.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      own_byte  = '0;
      own_valid = 1'b0;
      own_last  = 1'b0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         cand = IW'((32'(last_owner) + off) % NUM_REQ);
         if (!sel_found && req_valid[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (owner == IW'(i)) begin
            own_byte  = req_data[8*i +: 8];
            own_valid = req_valid[i];
            own_last  = req_last[i];
         end
      end
   end

`ifdef UART_ARB_WDOG_EN
   localparam int CW = $clog2(WDOG_CYCLES + 1);
   logic [CW-1:0] wdog_cnt;
`else
   assign wdog_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= LAST_IDX;
         last_q     <= 1'b0;
         grant      <= '0;
         req_ready  <= '0;
         tx_start   <= 1'b0;
         tx_data    <= 8'h00;
`ifdef UART_ARB_WDOG_EN
         wdog_cnt   <= '0;
         wdog_err   <= 1'b0;
`endif
      end else begin
         tx_start  <= 1'b0;
         req_ready <= '0;
`ifdef UART_ARB_WDOG_EN
         wdog_err  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (sel_found && !tx_busy) begin
                  owner <= sel_idx;
                  grant <= NUM_REQ'(1) << sel_idx;
                  state <= LOAD;
               end
            end
            LOAD: begin
               tx_start  <= 1'b1;
               tx_data   <= own_byte;
               req_ready <= grant;
               last_q    <= own_last;
               state     <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (tx_busy) state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  if (last_q) begin
                     grant      <= '0;
                     last_owner <= owner;
                     state      <= IDLE;
                  end else begin
                     state <= NEXT;
                  end
               end
            end
            NEXT: begin
               if (own_valid) begin
                  state <= LOAD;
`ifdef UART_ARB_WDOG_EN
                  wdog_cnt <= '0;
               end else if (wdog_cnt == CW'(WDOG_CYCLES - 1)) begin
                  wdog_cnt   <= '0;
                  wdog_err   <= 1'b1;
                  grant      <= '0;
                  last_owner <= owner;
                  state      <= IDLE;
               end else begin
                  wdog_cnt <= wdog_cnt + 1'b1;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues feed the DUT, a small busy model acts as the UART.
module tb_uart_tx_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   grant;
   logic           tx_start;
   logic [7:0]     tx_data;
   logic           tx_busy;
   logic           wdog_err;
   logic           ext_busy = 1'b0;
   int             busy_cnt = 0;

   uart_tx_arbiter #(.NUM_REQ(N), .WDOG_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .grant(grant),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .wdog_err(wdog_err)
   );

   always #5 clk = ~clk;

   // Transmitter stand-in: busy for 5 cycles starting the cycle after tx_start.
   assign tx_busy = (busy_cnt != 0) || ext_busy;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)        busy_cnt <= 0;
      else if (tx_start) busy_cnt <= 5;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end

   logic [7:0] sent_b[$];
   logic [3:0] sent_g[$];
   int         rdy_cnt[N];
   int         viol = 0;
   int         wd_cnt = 0;

   initial for (int i = 0; i < N; i++) rdy_cnt[i] = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (tx_start) begin
            sent_b.push_back(tx_data);
            sent_g.push_back(grant);
         end
         for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cnt[i] <= rdy_cnt[i] + 1;
         if (((req_ready & ~grant) != 4'b0) || ($countones(req_ready) > 1)) viol <= viol + 1;
         if (wdog_err) wd_cnt <= wd_cnt + 1;
      end
   end

   logic [7:0] rq_d[N][$];
   logic       rq_l[N][$];
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic update_inputs();
      for (int i = 0; i < N; i++) begin
         req_valid[i]        = rq_d[i].size() > 0;
         req_data[8*i +: 8]  = (rq_d[i].size() > 0) ? rq_d[i][0] : 8'h00;
         req_last[i]         = (rq_l[i].size() > 0) ? rq_l[i][0] : 1'b0;
      end
   endtask

   task automatic push(input int r, input logic [7:0] b, input logic l);
      rq_d[r].push_back(b);
      rq_l[r].push_back(l);
      update_inputs();
   endtask

   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (req_ready[i] && rq_d[i].size() > 0) begin
            void'(rq_d[i].pop_front());
            void'(rq_l[i].pop_front());
         end
      end
      update_inputs();
   endtask

   function automatic logic all_idle();
      logic e = 1'b1;
      for (int i = 0; i < N; i++) if (rq_d[i].size() != 0) e = 1'b0;
      return e && (grant == 4'b0) && !tx_busy;
   endfunction

   task automatic run_done(input string tag, input int max);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!all_idle() && n < max);
      check(tag, 32'(all_idle()), 32'd1);
   endtask

   task automatic chk_tx(input string tag, input int idx, input logic [7:0] b, input logic [3:0] g);
      check({tag, "_data"},  32'(sent_b[idx]), 32'(b));
      check({tag, "_grant"}, 32'(sent_g[idx]), 32'(g));
   endtask

   task automatic chk_reset_outputs(input string tag);
      check({tag, "_grant"},    32'(grant),     32'h0);
      check({tag, "_tx_start"}, 32'(tx_start),  32'h0);
      check({tag, "_req_ready"},32'(req_ready), 32'h0);
      check({tag, "_tx_data"},  32'(tx_data),   32'h0);
      check({tag, "_wdog_err"}, 32'(wdog_err),  32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int sb, r0, k, rsum;
      update_inputs();

      // Reset state
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      tick();

      // Single byte from requester 1, 2-cycle latency
      sb = sent_b.size();
      r0 = rdy_cnt[1];
      push(1, 8'hA5, 1'b1);
      tick();
      check("lat_grant", 32'(grant), 32'h2);
      check("lat_start0", 32'(tx_start), 32'h0);
      tick();
      check("lat_start1", 32'(tx_start), 32'h1);
      check("lat_data", 32'(tx_data), 32'hA5);
      check("lat_ready", 32'(req_ready), 32'h2);
      tick();
      check("start_pulse", 32'(tx_start), 32'h0);
      check("busy_seen", 32'(tx_busy), 32'h1);
      run_done("single_done", 60);
      check("single_cnt", 32'(sent_b.size() - sb), 32'd1);
      check("single_rdy", 32'(rdy_cnt[1] - r0), 32'd1);

      // Round robin after reset: 0, 2, then 0 again
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      sb = sent_b.size();
      push(0, 8'h10, 1'b1);
      push(2, 8'h20, 1'b1);
      push(0, 8'h11, 1'b1);
      run_done("rr_done", 200);
      check("rr_cnt", 32'(sent_b.size() - sb), 32'd3);
      chk_tx("rr0", sb,     8'h10, 4'b0001);
      chk_tx("rr1", sb + 1, 8'h20, 4'b0100);
      chk_tx("rr2", sb + 2, 8'h11, 4'b0001);

      // Burst on 3 is not interleaved with 0
      sb = sent_b.size();
      push(3, 8'h01, 1'b0);
      push(3, 8'h02, 1'b0);
      push(3, 8'h03, 1'b1);
      push(0, 8'h40, 1'b1);
      run_done("burst_done", 300);
      check("burst_cnt", 32'(sent_b.size() - sb), 32'd4);
      chk_tx("burst0", sb,     8'h01, 4'b1000);
      chk_tx("burst1", sb + 1, 8'h02, 4'b1000);
      chk_tx("burst2", sb + 2, 8'h03, 4'b1000);
      chk_tx("burst3", sb + 3, 8'h40, 4'b0001);

      // Lone requester granted repeatedly
      sb = sent_b.size();
      push(2, 8'hB0, 1'b1);
      push(2, 8'hB1, 1'b1);
      push(2, 8'hB2, 1'b1);
      run_done("solo_done", 300);
      check("solo_cnt", 32'(sent_b.size() - sb), 32'd3);
      chk_tx("solo2", sb + 2, 8'hB2, 4'b0100);

      // External busy holds arbitration off
      sb = sent_b.size();
      ext_busy = 1'b1;
      push(1, 8'h55, 1'b1);
      repeat (4) tick();
      check("extbusy_grant", 32'(grant), 32'h0);
      check("extbusy_nostart", 32'(sent_b.size() - sb), 32'd0);
      ext_busy = 1'b0;
      tick();
      check("extbusy_grant1", 32'(grant), 32'h2);
      tick();
      check("extbusy_start", 32'(tx_start), 32'h1);
      check("extbusy_data", 32'(tx_data), 32'h55);
      run_done("extbusy_done", 60);

      // Reset during WAIT_DONE abandons the burst
      push(2, 8'hA0, 1'b0);
      push(2, 8'hA1, 1'b1);
      k = 0;
      do begin tick(); k++; end while (!tx_busy && k < 20);
      check("midrst_busy", 32'(tx_busy), 32'h1);
      tick();
      tick();
      rst_n = 1'b0;
      rq_d[2].delete();
      rq_l[2].delete();
      update_inputs();
      #1;
      chk_reset_outputs("midrst");
      tick();
      rst_n = 1'b1;
      rsum = rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2] + rdy_cnt[3];
      repeat (5) tick();
      check("midrst_noready", 32'(rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2] + rdy_cnt[3] - rsum), 32'd0);
      check("midrst_grant", 32'(grant), 32'h0);

      // Pointer wrap: 0 beats 3 after reset
      sb = sent_b.size();
      push(3, 8'hC3, 1'b1);
      push(0, 8'hC0, 1'b1);
      run_done("wrap_done", 200);
      chk_tx("wrap0", sb,     8'hC0, 4'b0001);
      chk_tx("wrap1", sb + 1, 8'hC3, 4'b1000);

`ifdef UART_ARB_WDOG_EN
      // Owner 1 stalls after a non-last byte; watchdog hands over to 2
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      sb = sent_b.size();
      push(1, 8'h70, 1'b0);
      push(2, 8'h80, 1'b1);
      k = 0;
      do begin tick(); k++; end while (!tx_busy && k < 20);
      k = 0;
      do begin tick(); k++; end while (tx_busy && k < 20);
      k = 0;
      do begin tick(); k++; end while (!wdog_err && k < 40);
      check("wdog_delay", 32'(k), 32'd17);
      check("wdog_grant", 32'(grant), 32'h0);
      run_done("wdog_done", 100);
      chk_tx("wdog0", sb,     8'h70, 4'b0010);
      chk_tx("wdog1", sb + 1, 8'h80, 4'b0100);
      check("wdog_pulses", 32'(wd_cnt), 32'd1);
`else
      check("wdog_never", 32'(wd_cnt), 32'd0);
`endif

      check("ready_rules", 32'(viol), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
